// File: rtl/apu_pkg.sv
// Shared constants for the APU frame sequencer: mode encodings, per-mode
// step limits and the bit layout of the per-step event vector.
package apu_pkg;

  localparam logic MODE_4STEP = 1'b0;
  localparam logic MODE_5STEP = 1'b1;

  localparam int unsigned STEP_CYCLES_DEFAULT = 3728;

  localparam int unsigned STEP_W = 3;
  typedef logic [STEP_W-1:0] step_t;

  localparam step_t LAST_STEP_4 = 3'd3;
  localparam step_t LAST_STEP_5 = 3'd4;

  // Event vector produced by frame_step_decode for the current (mode, step).
  localparam int unsigned EV_QTR  = 0;
  localparam int unsigned EV_HALF = 1;
  localparam int unsigned EV_IRQ  = 2;
  localparam int unsigned EV_LAST = 3;
  localparam int unsigned EV_W    = 4;

  typedef logic [EV_W-1:0] events_t;

endpackage

// File: rtl/frame_step_decode.sv
// Combinational event table: which strobes fire when the given step of the
// given mode completes, and whether that step is the last one of the mode.
module frame_step_decode
  import apu_pkg::*;
(
  input  logic    mode,
  input  step_t   step,
  output events_t events
);

  always_comb begin
    events = '0;
    if (mode == MODE_4STEP) begin
      events[EV_QTR]  = (step <= LAST_STEP_4);
      events[EV_HALF] = (step == 3'd1) || (step == 3'd3);
      events[EV_IRQ]  = (step == LAST_STEP_4);
      // Out-of-range steps are treated as last so the sequence recovers.
      events[EV_LAST] = (step >= LAST_STEP_4);
    end else begin
      events[EV_QTR]  = (step <= 3'd2) || (step == LAST_STEP_5);
      events[EV_HALF] = (step == 3'd1) || (step == LAST_STEP_5);
      events[EV_IRQ]  = 1'b0;
      events[EV_LAST] = (step >= LAST_STEP_5);
    end
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides the APU tick into frame steps and emits the
// quarter/half-frame strobes plus the sticky frame interrupt flag.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       cfg_write,
  input  logic       cfg_mode,
  input  logic       cfg_irq_inhibit,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  step_t            step_q, step_d;
  logic             mode_q, mode_d;
  logic             inhibit_q, inhibit_d;
  logic             qtr_q, qtr_d;
  logic             half_q, half_d;
  logic             irq_q, irq_d;
  logic             terminal;
  events_t          events;

  frame_step_decode u_step_decode (
    .mode   (mode_q),
    .step   (step_q),
    .events (events)
  );

  assign terminal = tick && (cnt_q == CntLast);

  always_comb begin
    cnt_d     = cnt_q;
    step_d    = step_q;
    mode_d    = mode_q;
    inhibit_d = inhibit_q;
    qtr_d     = 1'b0;
    half_d    = 1'b0;
    irq_d     = irq_q;

    if (irq_ack) begin
      irq_d = 1'b0;
    end

    // A register write restarts the sequence and swallows a coincident terminal.
    if (cfg_write) begin
      mode_d    = cfg_mode;
      inhibit_d = cfg_irq_inhibit;
      cnt_d     = '0;
      step_d    = '0;
      qtr_d     = (cfg_mode == MODE_5STEP);
      half_d    = (cfg_mode == MODE_5STEP);
      if (cfg_irq_inhibit) begin
        irq_d = 1'b0;
      end
    end else if (terminal) begin
      cnt_d  = '0;
      qtr_d  = events[EV_QTR];
      half_d = events[EV_HALF];
      step_d = events[EV_LAST] ? step_t'(0) : step_q + 3'd1;
      // Set overrides a same-cycle irq_ack.
      if (events[EV_IRQ] && !inhibit_q) begin
        irq_d = 1'b1;
      end
    end else if (tick) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      step_q    <= '0;
      mode_q    <= MODE_4STEP;
      inhibit_q <= 1'b0;
      qtr_q     <= 1'b0;
      half_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      mode_q    <= mode_d;
      inhibit_q <= inhibit_d;
      qtr_q     <= qtr_d;
      half_q    <= half_d;
      irq_q     <= irq_d;
    end
  end

  assign quarter_frame = qtr_q;
  assign half_frame    = half_q;
  assign frame_irq     = irq_q;
  assign step          = step_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with STEP_CYCLES=4; observed
// vector is {quarter_frame, half_frame, frame_irq, step}.
module tb_apu_frame_sequencer;

  localparam int unsigned STEP_CYCLES = 4;
  localparam int unsigned CNT_W       = 14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       cfg_write = 1'b0;
  logic       cfg_mode = 1'b0;
  logic       cfg_irq_inhibit = 1'b0;
  logic       irq_ack = 1'b0;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic [2:0] step;
  logic [5:0] obs;

  int vectors = 0;
  int miscompares = 0;

  apu_frame_sequencer #(
    .STEP_CYCLES (STEP_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .cfg_write       (cfg_write),
    .cfg_mode        (cfg_mode),
    .cfg_irq_inhibit (cfg_irq_inhibit),
    .irq_ack         (irq_ack),
    .quarter_frame   (quarter_frame),
    .half_frame      (half_frame),
    .frame_irq       (frame_irq),
    .step            (step)
  );

  assign obs = {quarter_frame, half_frame, frame_irq, step};

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic mode, input logic inh);
    cfg_write = 1'b1;
    cfg_mode = mode;
    cfg_irq_inhibit = inh;
    cycle();
    cfg_write = 1'b0;
    cfg_mode = 1'b0;
    cfg_irq_inhibit = 1'b0;
  endtask

  // Mode-0 expectation t edges after a restart with tick held high.
  function automatic logic [5:0] exp4(input int t, input logic irq);
    logic q, h;
    logic [2:0] s;
    q = (t > 0) && (t % 4 == 0);
    h = (t > 0) && (t % 8 == 0);
    s = 3'((t / 4) % 4);
    return {q, h, irq, s};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    tick = 1'b0;
    repeat (2) cycle();
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, want %b", obs, 6'b0);
    end
    tick = 1'b1;
    cycle();
    vectors++;
    if (obs !== 6'b0 || dut.cnt_q !== CNT_W'(0)) begin
      miscompares++;
      $display("FAIL reset_hold_with_tick: got %b cnt=%0d, want 000000 cnt=0", obs, dut.cnt_q);
    end
  endtask

  task automatic test_four_step();
    logic [5:0] e;
    rst_n = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      cycle();
      e = exp4(t, t >= 16);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL four_step t=%0d: got %b, want %b", t, obs, e);
      end
    end
  endtask

  task automatic test_irq();
    logic [5:0] e;
    write_cfg(1'b0, 1'b1);
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL irq_inhibit_clear: got %b, want %b", obs, 6'b0);
    end
    write_cfg(1'b0, 1'b0);
    for (int t = 1; t <= 32; t++) begin
      irq_ack = (t == 19) || (t == 32);
      cycle();
      irq_ack = 1'b0;
      e = exp4(t, ((t >= 16) && (t < 19)) || (t >= 32));
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL irq_ack t=%0d: got %b, want %b", t, obs, e);
      end
    end
    write_cfg(1'b0, 1'b1);
    vectors++;
    if (obs !== 6'b0) begin
      miscompares++;
      $display("FAIL irq_inhibit_write: got %b, want %b", obs, 6'b0);
    end
    for (int t = 1; t <= 32; t++) begin
      cycle();
      e = exp4(t, 1'b0);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL irq_inhibited t=%0d: got %b, want %b", t, obs, e);
      end
    end
  endtask

  task automatic test_five_step();
    logic [5:0] e;
    logic term, q, h;
    int s;
    write_cfg(1'b1, 1'b0);
    vectors++;
    if (obs !== 6'b110000) begin
      miscompares++;
      $display("FAIL five_step_immediate: got %b, want %b", obs, 6'b110000);
    end
    for (int t = 1; t <= 60; t++) begin
      cycle();
      term = (t % 4 == 0);
      s = (t / 4 + 4) % 5;
      q = term && (s != 3);
      h = term && ((s == 1) || (s == 4));
      e = {q, h, 1'b0, 3'((t / 4) % 5)};
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL five_step t=%0d: got %b, want %b", t, obs, e);
      end
    end
  endtask

  task automatic test_collision();
    logic [5:0] e;
    repeat (3) cycle();
    vectors++;
    if (dut.cnt_q !== CNT_W'(3) || obs !== 6'b0) begin
      miscompares++;
      $display("FAIL collision_setup: got cnt=%0d obs=%b, want cnt=3 obs=000000", dut.cnt_q, obs);
    end
    write_cfg(1'b0, 1'b0);
    vectors++;
    if (obs !== 6'b0 || dut.cnt_q !== CNT_W'(0)) begin
      miscompares++;
      $display("FAIL collision_restart: got %b cnt=%0d, want 000000 cnt=0", obs, dut.cnt_q);
    end
    for (int t = 1; t <= 4; t++) begin
      cycle();
      e = exp4(t, 1'b0);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL collision_after t=%0d: got %b, want %b", t, obs, e);
      end
    end
  endtask

  task automatic test_sparse_tick();
    logic [5:0] e;
    logic term;
    int ticks, k;
    write_cfg(1'b0, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      tick = (c % 3 == 1);
      cycle();
      tick = 1'b0;
      ticks = (c + 2) / 3;
      k = ticks / 4;
      term = (c % 3 == 1) && (ticks % 4 == 0);
      e = {term, term && (k % 2 == 0), 1'b0, 3'(k % 4)};
      vectors++;
      if (obs !== e || dut.cnt_q !== CNT_W'(ticks % 4)) begin
        miscompares++;
        $display("FAIL sparse_tick c=%0d: got %b cnt=%0d, want %b cnt=%0d",
                 c, obs, dut.cnt_q, e, ticks % 4);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] e;
    tick = 1'b1;
    write_cfg(1'b0, 1'b0);
    repeat (26) cycle();
    vectors++;
    if (obs !== 6'b001010 || dut.cnt_q !== CNT_W'(2)) begin
      miscompares++;
      $display("FAIL async_setup: got %b cnt=%0d, want 001010 cnt=2", obs, dut.cnt_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 6'b0 || dut.cnt_q !== CNT_W'(0)) begin
      miscompares++;
      $display("FAIL async_immediate: got %b cnt=%0d, want 000000 cnt=0", obs, dut.cnt_q);
    end
    #4;
    rst_n = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      cycle();
      e = exp4(t, 1'b0);
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL async_resume t=%0d: got %b, want %b", t, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_four_step();
    test_irq();
    test_five_step();
    test_collision();
    test_sparse_tick();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
